// File: rtl/shift_seq8.sv
// shift_seq8: sequential 8-bit shift engine.
// Latches an operand, shift amount (0-7) and operation on start, then walks
// the shift through a 0-3 position per-cycle datapath until the full amount
// has been applied. The result is presented on a registered d_out together
// with a single-cycle done pulse.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   start  - begin a shift (accepted in IDLE or DONE, ignored in SHIFT)
//   op     - 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   d_in   - operand
//   shamt  - total shift amount 0-7
//   d_out  - registered result, held until the next completion
//   busy   - high while shifting
//   done   - one-cycle pulse when d_out carries a new result
//
// Build option: define SHIFT_SEQ8_ROR_EN to build the rotate datapath.
// Without it, op=11 completes immediately as a pass-through (d_out=d_in).
module shift_seq8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned W = 8;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_d_out;
    logic [2:0]   r_rem;
    logic [1:0]   r_op_q;

    logic         w_accept;
    logic         w_zero;
    logic         w_last;
    logic [1:0]   w_step;
    logic [W-1:0] w_shifted;

    // One datapath step: shift a by n (0-3) positions, a 4:1 choice per bit.
    function automatic logic [W-1:0] f_shift(input logic [W-1:0] a,
                                             input logic [1:0]   o,
                                             input logic [1:0]   n);
`ifdef SHIFT_SEQ8_ROR_EN
        logic [2*W-1:0] dbl;
        dbl = {a, a} >> n;
`endif
        case (o)
            OP_LSL:  f_shift = a << n;
            OP_LSR:  f_shift = a >> n;
            OP_ASR:  f_shift = W'($signed(a) >>> n);
`ifdef SHIFT_SEQ8_ROR_EN
            OP_ROR:  f_shift = dbl[W-1:0];
`endif
            default: f_shift = a;
        endcase
    endfunction

    // Accept decode; zero-length requests skip SHIFT entirely.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
`ifdef SHIFT_SEQ8_ROR_EN
    assign w_zero   = (shamt == 3'd0);
`else
    assign w_zero   = (shamt == 3'd0) || (op == OP_ROR);
`endif

    // Per-cycle step is capped at 3; last step when the remainder fits.
    assign w_step    = (r_rem > 3'd3) ? 2'd3 : r_rem[1:0];
    assign w_last    = (r_rem <= 3'd3);
    assign w_shifted = f_shift(r_acc, r_op_q, w_step);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, iterative shift, and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_op_q  <= '0;
            r_d_out <= '0;
        end else if (w_accept) begin
            r_acc  <= d_in;
            r_rem  <= shamt;
            r_op_q <= op;
            if (w_zero) begin
                r_d_out <= d_in;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_shifted;
            r_rem <= r_rem - {1'b0, w_step};
            if (w_last) begin
                r_d_out <= w_shifted;
            end
        end
    end

    assign d_out = r_d_out;

endmodule
